ringbus_rx_deser: RTL



---
 rtl/ringbus_rx_deser.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ringbus_rx_deser.sv
// Ringbus serial receiver: idle-high 1-bit line to framed 32-bit words in a FWFT FIFO.
// Define RINGBUS_RX_PARITY_EN to expect an even-parity bit between data and stop.
module ringbus_rx_deser #(
    parameter int BIT_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_ringbus,
    output logic [31:0]      o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_frame_err,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam int PH_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    // The IDLE detect cycle is phase 0 of the start bit, so mid-bit is BIT_CYCLES/2.
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(BIT_CYCLES / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [AW:0]     PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef RINGBUS_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t          state, state_n;
    logic            rb_q;
    logic            live;
    logic            armed, armed_n;
    logic [PH_W-1:0] ph, ph_n;
    logic [4:0]      bc, bc_n;
    logic [31:0]     sr, sr_n;
    logic            samp;
    logic            push;
    logic            bad;
    logic            par_fault;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, do_push, drop;

    assign samp = (ph == PH_MID);

`ifdef RINGBUS_RX_PARITY_EN
    logic par, par_n;
    assign par_fault = ^{sr, par};
`else
    assign par_fault = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ph_n    = (ph == PH_LAST) ? '0 : ph + PH_ONE;
        bc_n    = bc;
        sr_n    = sr;
        armed_n = armed;
        push    = 1'b0;
        bad     = 1'b0;
`ifdef RINGBUS_RX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            S_IDLE: begin
                ph_n = '0;
                if (rb_q && live)
                    armed_n = 1'b1;
                if (armed && !rb_q) begin
                    state_n = S_START;
                    ph_n    = PH_ONE;
                end
            end
            S_START: begin
                if (samp) begin
                    if (rb_q) begin
                        state_n = S_IDLE;
                    end else begin
                        bc_n    = '0;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (samp) begin
                    sr_n = {sr[30:0], rb_q};
                    bc_n = bc + 5'd1;
                    if (bc == 5'd31) begin
`ifdef RINGBUS_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef RINGBUS_RX_PARITY_EN
            S_PARITY: begin
                if (samp) begin
                    par_n   = rb_q;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (samp) begin
                    armed_n = 1'b0;
                    state_n = S_IDLE;
                    if (rb_q && !par_fault)
                        push = 1'b1;
                    else
                        bad = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
    assign o_valid = !empty;
    assign o_data  = mem[rd_ptr[AW-1:0]];
    assign pop     = o_valid && i_ready;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // live gates arming until rb_q has been loaded from the line after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rb_q        <= 1'b1;
            live        <= 1'b0;
            armed       <= 1'b0;
            state       <= S_IDLE;
            ph          <= '0;
            bc          <= '0;
            sr          <= '0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
            o_err_cnt   <= '0;
            o_drop_cnt  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
`ifdef RINGBUS_RX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            rb_q        <= i_ringbus;
            live        <= 1'b1;
            armed       <= armed_n;
            state       <= state_n;
            ph          <= ph_n;
            bc          <= bc_n;
            sr          <= sr_n;
            o_frame_err <= bad;
`ifdef RINGBUS_RX_PARITY_EN
            par         <= par_n;
`endif
            if (bad && !(&o_err_cnt))
                o_err_cnt <= o_err_cnt + CNT_ONE;
            if (drop) begin
                o_overflow <= 1'b1;
                if (!(&o_drop_cnt))
                    o_drop_cnt <= o_drop_cnt + CNT_ONE;
            end
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= sr;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule
